scaler_line_scheduler: RTL and testbench
========================================

Name: scaler_line_scheduler

Overview:
Sequencing controller for the 3x video line-replication datapath. Owns a ring of NBANKS line-buffer banks.
- Write side: assigns a free bank to each incoming native line.
- Read side: hands the same bank to the output timing SCALE times, then releases it.
- Detects overrun (no free bank at native line start) and underrun (no full bank at output line request).
- Resynchronises both sides on native vsync.

Parameters:
NBANKS, 3, number of line-buffer banks in the ring (2..4)
SCALE, 3, output lines generated per native line (1..4)
PRIME_LINES, 1, full banks required after vsync before the first output line is served (1..NBANKS)
LINE_W, 9, width of native source-line counter

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_de  in  1  native data enable; high for the active pixels of a line
in_vs  in  1  native vsync; rising edge = new frame
out_line_req  in  1  pulse: output timing starts an active line
out_line_done  in  1  pulse: output timing finished reading the current line
wr_active  out  1  datapath may write the current native pixel into wr_bank
wr_bank  out  2  bank being filled
rd_valid  out  1  rd_bank holds valid data for the current output line; 0 = output black
rd_bank  out  2  bank to read for the current output line
rd_rep  out  2  replica index 0..SCALE-1 of the current output line
rd_src_line  out  LINE_W  native line number held in rd_bank
fill_level  out  $clog2(NBANKS+1)  number of banks in FULL or READING state
overrun  out  1  one-cycle pulse: native line dropped
underrun  out  1  one-cycle pulse: output line served as black in RUN

Behaviour:
- Reset (async, rst_n low): every output is 0. All banks are FREE. Write pointer wp, read pointer rp, source-line counter and replica counter are 0. Write FSM is W_IDLE; read FSM is R_PRIME.
- Edge detection: in_de and in_vs are registered into de_q and vs_q. A rise is in & !q; a fall is !in & q. Every action below updates registered state on the cycle after the sampled edge. The datapath delays pixels by 1 cycle to align with wr_active.
- Bank state: each bank holds a 2-bit state FREE/FILLING/FULL/READING plus a stored source-line number. Both FSMs read the registered state only. A bank that becomes FULL or FREE in cycle t is eligible from cycle t+1.
- Write FSM:
  - W_IDLE, de rise, bank[wp] FREE: bank becomes FILLING, wr_bank=wp, wr_active=1, go to W_ACTIVE.
  - W_IDLE, de rise, bank[wp] not FREE: overrun pulse, go to W_DROP with wr_active=0.
  - W_ACTIVE, de fall: bank becomes FULL with the source-line number, wp=wp+1 mod NBANKS, srcline++, wr_active=0, go to W_IDLE.
  - W_DROP, de fall: srcline++, go to W_IDLE.
- Read FSM:
  - R_PRIME, out_line_req with fill_level < PRIME_LINES: rd_valid=0, no underrun.
  - R_PRIME, out_line_req with fill_level >= PRIME_LINES: go to R_RUN and serve the request.
  - R_RUN serve, rep==0: if bank[rp] FULL, it becomes READING with rd_valid=1, rd_bank=rp, rd_rep=0. Otherwise rd_valid=0, underrun pulse, rep stays 0.
  - R_RUN serve, rep>0: same bank, rd_rep=rep.
  - out_line_done with rd_valid=1: rep++. When rep reaches SCALE, bank[rp] becomes FREE, rp++ mod NBANKS, rep=0.
  - out_line_req while a valid line is outstanding (done not yet received) is ignored.
  - out_line_req and out_line_done in the same cycle: done is processed first.
- Vsync rise has priority over all other events:
  - All banks become FREE; wp, rp, rep and srcline return to 0.
  - Write FSM goes to W_IDLE (a line mid-write is aborted; wr_active=0 next cycle).
  - Read FSM goes to R_PRIME with rd_valid=0.
  - A de rise in the same cycle as the vsync rise is processed after the clear.
- Counters wrap silently: pointers mod NBANKS, srcline mod 2^LINE_W.

Optional Feature:
SCALER_SCHED_STATS_EN:
- When defined: adds outputs stat_overruns[15:0] and stat_underruns[15:0]. Each is a saturating count for the current frame, latched into output registers and cleared on every vsync rise.
- When undefined: these ports and registers do not exist; all other behaviour is identical.

Decomposition:
- Package scaler_pkg holds:
  - bank_state_t enum: FREE, FILLING, FULL, READING.
  - wr_state_t: W_IDLE, W_ACTIVE, W_DROP.
  - rd_state_t: R_PRIME, R_RUN.
  - Constant MAX_BANKS=4.
- One sub-module, scaler_edge_detect, registers a signal and produces rise/fall pulses. It is instantiated for in_de and in_vs.

Test Plan:
- Steady state: vsync, then native lines 0..5, each followed by 3 req/done output pairs. Expect rd_bank 0,0,0,1,1,1,2,2,2,0,…; rd_rep 0,1,2 repeating; rd_src_line increments per triple; no overrun/underrun.
- Prime: vsync, then req before line 0 completes. Expect rd_valid=0 and no underrun. After the line 0 de fall, the next req gives rd_valid=1, rd_bank=0, rd_src_line=0.
- Overrun: hold off out_line_done and feed 4 native lines. Banks 0..2 fill, fill_level=3. Line 3 produces one overrun pulse with wr_active low for the whole line; srcline then reads 4.
- Underrun: in R_RUN after all banks are consumed, issue req with fill_level=0. Expect rd_valid=0, one underrun pulse, rep=0. After the next line completes, req serves it with rd_rep=0.
- Vsync mid-line: in_vs rises during W_ACTIVE. Next cycle: wr_active=0, fill_level=0, read FSM in R_PRIME; the following line is written to bank 0.
- Async reset asserted mid-line: all outputs are 0 immediately, with no clock edge needed. After release, the first line is written to bank 0.

Source files
------------

// File: rtl/scaler_pkg.sv
// scaler_pkg: shared types and constants for the line scheduler.
package scaler_pkg;

  localparam int unsigned MAX_BANKS = 4;
  localparam int unsigned PTR_W     = 2;
  localparam int unsigned REP_W     = 2;
  localparam int unsigned STAT_W    = 16;

  typedef enum logic [1:0] {FREE, FILLING, FULL, READING} bank_state_t;
  typedef enum logic [1:0] {W_IDLE, W_ACTIVE, W_DROP} wr_state_t;
  typedef enum logic {R_PRIME, R_RUN} rd_state_t;

  // Ring pointer increment modulo the configured bank count.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p, input int unsigned n);
    return (32'(p) + 32'd1 >= n) ? '0 : p + PTR_W'(1);
  endfunction

endpackage

// File: rtl/scaler_line_scheduler_if.sv
// scaler_line_scheduler_if: native/output timing strobes and bank sequencing results.
// Optional: SCALER_SCHED_STATS_EN adds per-frame statistics counters.
interface scaler_line_scheduler_if #(
  parameter int unsigned NBANKS = 3,
  parameter int unsigned LINE_W = 9
);
  localparam int unsigned FILL_W = $clog2(NBANKS + 1);

  logic              in_de;
  logic              in_vs;
  logic              out_line_req;
  logic              out_line_done;
  logic              wr_active;
  logic [1:0]        wr_bank;
  logic              rd_valid;
  logic [1:0]        rd_bank;
  logic [1:0]        rd_rep;
  logic [LINE_W-1:0] rd_src_line;
  logic [FILL_W-1:0] fill_level;
  logic              overrun;
  logic              underrun;
`ifdef SCALER_SCHED_STATS_EN
  logic [15:0]       stat_overruns;
  logic [15:0]       stat_underruns;
`endif

  modport master (
`ifdef SCALER_SCHED_STATS_EN
    input  stat_overruns, stat_underruns,
`endif
    output in_de, in_vs, out_line_req, out_line_done,
    input  wr_active, wr_bank, rd_valid, rd_bank, rd_rep, rd_src_line,
    input  fill_level, overrun, underrun
  );

  modport slave (
`ifdef SCALER_SCHED_STATS_EN
    output stat_overruns, stat_underruns,
`endif
    input  in_de, in_vs, out_line_req, out_line_done,
    output wr_active, wr_bank, rd_valid, rd_bank, rd_rep, rd_src_line,
    output fill_level, overrun, underrun
  );

endinterface

// File: rtl/scaler_edge_detect.sv
// scaler_edge_detect: registers a level and flags its rising/falling transitions.
module scaler_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise_c,
  output logic fall_c
);
  logic q;

  // Previous-cycle copy of the input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= 1'b0;
    else        q <= d;
  end

  assign rise_c = d & ~q;
  assign fall_c = ~d & q;
endmodule

// File: rtl/scaler_line_scheduler.sv
// scaler_line_scheduler: bank ring sequencer for the 3x line-replication datapath.
// Optional: define SCALER_SCHED_STATS_EN for per-frame overrun/underrun counters.
module scaler_line_scheduler
  import scaler_pkg::*;
#(
  parameter int unsigned NBANKS      = 3,
  parameter int unsigned SCALE       = 3,
  parameter int unsigned PRIME_LINES = 1,
  parameter int unsigned LINE_W      = 9
) (
  input logic                    clk,
  input logic                    rst_n,
  scaler_line_scheduler_if.slave bus
);
  localparam int unsigned FILL_W = $clog2(NBANKS + 1);

  logic de_rise, de_fall, vs_rise, vs_fall_unused;

  scaler_edge_detect u_de_edge (.clk(clk), .rst_n(rst_n), .d(bus.in_de),
                                .rise_c(de_rise), .fall_c(de_fall));
  scaler_edge_detect u_vs_edge (.clk(clk), .rst_n(rst_n), .d(bus.in_vs),
                                .rise_c(vs_rise), .fall_c(vs_fall_unused));

  wr_state_t         wr_st, wr_st_n;
  rd_state_t         rd_st, rd_st_n;
  bank_state_t       bank_st   [NBANKS];
  bank_state_t       bank_st_n [NBANKS];
  logic [LINE_W-1:0] bank_line   [NBANKS];
  logic [LINE_W-1:0] bank_line_n [NBANKS];
  logic [PTR_W-1:0]  wp, wp_n, rp, rp_n, rp_d;
  logic [REP_W-1:0]  rep, rep_n, rep_d;
  logic [LINE_W-1:0] srcline, srcline_n;
  logic              line_open;

  logic              wr_active_q, wr_active_n;
  logic [PTR_W-1:0]  wr_bank_q, wr_bank_n;
  logic              rd_valid_q, rd_valid_n;
  logic [PTR_W-1:0]  rd_bank_q, rd_bank_n;
  logic [REP_W-1:0]  rd_rep_q, rd_rep_n;
  logic [LINE_W-1:0] rd_src_q, rd_src_n;
  logic [FILL_W-1:0] fill_q, fill_n;
  logic              overrun_q, overrun_n;
  logic              underrun_q, underrun_n;

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_st <= W_IDLE;
      rd_st <= R_PRIME;
      for (int unsigned i = 0; i < NBANKS; i++) begin
        bank_st[i]   <= FREE;
        bank_line[i] <= '0;
      end
      wp          <= '0;
      rp          <= '0;
      rep         <= '0;
      srcline     <= '0;
      wr_active_q <= 1'b0;
      wr_bank_q   <= '0;
      rd_valid_q  <= 1'b0;
      rd_bank_q   <= '0;
      rd_rep_q    <= '0;
      rd_src_q    <= '0;
      fill_q      <= '0;
      overrun_q   <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      wr_st       <= wr_st_n;
      rd_st       <= rd_st_n;
      bank_st     <= bank_st_n;
      bank_line   <= bank_line_n;
      wp          <= wp_n;
      rp          <= rp_n;
      rep         <= rep_n;
      srcline     <= srcline_n;
      wr_active_q <= wr_active_n;
      wr_bank_q   <= wr_bank_n;
      rd_valid_q  <= rd_valid_n;
      rd_bank_q   <= rd_bank_n;
      rd_rep_q    <= rd_rep_n;
      rd_src_q    <= rd_src_n;
      fill_q      <= fill_n;
      overrun_q   <= overrun_n;
      underrun_q  <= underrun_n;
    end
  end

  // Next-state for write FSM, read FSM and bank ring; vsync clears everything first.
  always_comb begin
    wr_st_n     = wr_st;
    rd_st_n     = rd_st;
    bank_st_n   = bank_st;
    bank_line_n = bank_line;
    wp_n        = wp;
    rp_n        = rp;
    rep_n       = rep;
    srcline_n   = srcline;
    wr_active_n = wr_active_q;
    wr_bank_n   = wr_bank_q;
    rd_valid_n  = rd_valid_q;
    rd_bank_n   = rd_bank_q;
    rd_rep_n    = rd_rep_q;
    rd_src_n    = rd_src_q;
    overrun_n   = 1'b0;
    underrun_n  = 1'b0;
    rp_d        = rp;
    rep_d       = rep;
    line_open   = rd_valid_q;
    fill_n      = '0;

    if (vs_rise) begin
      for (int unsigned i = 0; i < NBANKS; i++) bank_st_n[i] = FREE;
      wp_n        = '0;
      rp_n        = '0;
      rep_n       = '0;
      srcline_n   = '0;
      wr_st_n     = W_IDLE;
      wr_active_n = 1'b0;
      rd_st_n     = R_PRIME;
      rd_valid_n  = 1'b0;
      // A line starting together with vsync lands in the freshly cleared bank 0.
      if (de_rise) begin
        bank_st_n[0] = FILLING;
        wr_bank_n    = '0;
        wr_active_n  = 1'b1;
        wr_st_n      = W_ACTIVE;
      end
    end else begin
      unique case (wr_st)
        W_IDLE: begin
          if (de_rise) begin
            if (bank_st[wp] == FREE) begin
              bank_st_n[wp] = FILLING;
              wr_bank_n     = wp;
              wr_active_n   = 1'b1;
              wr_st_n       = W_ACTIVE;
            end else begin
              overrun_n = 1'b1;
              wr_st_n   = W_DROP;
            end
          end
        end
        W_ACTIVE: begin
          if (de_fall) begin
            bank_st_n[wp]   = FULL;
            bank_line_n[wp] = srcline;
            wp_n            = ptr_inc(wp, NBANKS);
            srcline_n       = srcline + LINE_W'(1);
            wr_active_n     = 1'b0;
            wr_st_n         = W_IDLE;
          end
        end
        W_DROP: begin
          if (de_fall) begin
            srcline_n = srcline + LINE_W'(1);
            wr_st_n   = W_IDLE;
          end
        end
        default: wr_st_n = W_IDLE;
      endcase

      // Completion of the outstanding output line is handled before any new request.
      if (bus.out_line_done && rd_valid_q) begin
        line_open  = 1'b0;
        rd_valid_n = 1'b0;
        if (32'(rep) + 32'd1 >= SCALE) begin
          bank_st_n[rp] = FREE;
          rp_d          = ptr_inc(rp, NBANKS);
          rep_d         = '0;
        end else begin
          rep_d = rep + REP_W'(1);
        end
      end
      rp_n  = rp_d;
      rep_n = rep_d;

      if (bus.out_line_req && !line_open) begin
        if ((rd_st == R_RUN) || (fill_q >= FILL_W'(PRIME_LINES))) begin
          rd_st_n = R_RUN;
          if (rep_d != '0) begin
            rd_valid_n = 1'b1;
            rd_bank_n  = rp_d;
            rd_rep_n   = rep_d;
            rd_src_n   = bank_line[rp_d];
          end else if (bank_st[rp_d] == FULL) begin
            bank_st_n[rp_d] = READING;
            rd_valid_n      = 1'b1;
            rd_bank_n       = rp_d;
            rd_rep_n        = '0;
            rd_src_n        = bank_line[rp_d];
          end else begin
            rd_valid_n = 1'b0;
            underrun_n = 1'b1;
          end
        end else begin
          rd_valid_n = 1'b0;
        end
      end
    end

    for (int unsigned i = 0; i < NBANKS; i++) begin
      if ((bank_st_n[i] == FULL) || (bank_st_n[i] == READING)) fill_n = fill_n + FILL_W'(1);
    end
  end

  assign bus.wr_active   = wr_active_q;
  assign bus.wr_bank     = wr_bank_q;
  assign bus.rd_valid    = rd_valid_q;
  assign bus.rd_bank     = rd_bank_q;
  assign bus.rd_rep      = rd_rep_q;
  assign bus.rd_src_line = rd_src_q;
  assign bus.fill_level  = fill_q;
  assign bus.overrun     = overrun_q;
  assign bus.underrun    = underrun_q;

`ifdef SCALER_SCHED_STATS_EN
  logic [STAT_W-1:0] stat_ovr_q, stat_und_q;

  // Saturating per-frame event counters, cleared at each new frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_ovr_q <= '0;
      stat_und_q <= '0;
    end else if (vs_rise) begin
      stat_ovr_q <= '0;
      stat_und_q <= '0;
    end else begin
      if (overrun_n && (stat_ovr_q != '1))  stat_ovr_q <= stat_ovr_q + STAT_W'(1);
      if (underrun_n && (stat_und_q != '1)) stat_und_q <= stat_und_q + STAT_W'(1);
    end
  end

  assign bus.stat_overruns  = stat_ovr_q;
  assign bus.stat_underruns = stat_und_q;
`endif

endmodule

// File: tb/tb_scaler_line_scheduler.sv
// tb_scaler_line_scheduler: directed scenarios plus random traffic against a line-queue model.
module tb_scaler_line_scheduler;
  localparam int NB    = 3;
  localparam int SC    = 3;
  localparam int PRIME = 1;
  localparam int LW    = 9;

  logic clk;
  logic rst_n;

  scaler_line_scheduler_if #(.NBANKS(NB), .LINE_W(LW)) bus ();

  scaler_line_scheduler #(.NBANKS(NB), .SCALE(SC), .PRIME_LINES(PRIME), .LINE_W(LW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_chk  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Model: queue of written lines (bank, source line) awaiting/under readout.
  int mq_bank[$];
  int mq_src[$];
  int m_wp, m_src, m_rep, m_wmode, n_pre;
  bit m_open, m_run, m_de_q, m_vs_q;
  bit de_r, de_f, vs_r;
  int e_wr_active, e_wr_bank, e_rd_valid, e_rd_bank, e_rd_rep, e_rd_src;
  int e_fill, e_ovr, e_und, e_so, e_su;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq_bank.delete(); mq_src.delete();
      m_wp = 0; m_src = 0; m_rep = 0; m_wmode = 0;
      m_open = 0; m_run = 0; m_de_q = 0; m_vs_q = 0;
      e_wr_active = 0; e_wr_bank = 0; e_rd_valid = 0; e_rd_bank = 0; e_rd_rep = 0;
      e_rd_src = 0; e_fill = 0; e_ovr = 0; e_und = 0; e_so = 0; e_su = 0;
    end else begin
      de_r = bus.in_de && !m_de_q;
      de_f = !bus.in_de && m_de_q;
      vs_r = bus.in_vs && !m_vs_q;
      m_de_q = bus.in_de;
      m_vs_q = bus.in_vs;
      e_ovr = 0;
      e_und = 0;
      n_pre = mq_bank.size();
      if (vs_r) begin
        mq_bank.delete(); mq_src.delete();
        m_wp = 0; m_src = 0; m_rep = 0; m_open = 0; m_run = 0;
        e_rd_valid = 0; e_wr_active = 0; m_wmode = 0; e_so = 0; e_su = 0;
        if (de_r) begin m_wmode = 1; e_wr_active = 1; e_wr_bank = 0; end
      end else begin
        if (bus.out_line_done && m_open) begin
          m_open = 0; e_rd_valid = 0; m_rep++;
          if (m_rep == SC) begin
            void'(mq_bank.pop_front()); void'(mq_src.pop_front()); m_rep = 0;
          end
        end
        if (bus.out_line_req && !m_open) begin
          if (!m_run && n_pre < PRIME) e_rd_valid = 0;
          else begin
            m_run = 1;
            if (m_rep > 0 || mq_bank.size() > 0) begin
              m_open = 1; e_rd_valid = 1; e_rd_rep = m_rep;
              e_rd_bank = mq_bank[0]; e_rd_src = mq_src[0];
            end else begin
              e_rd_valid = 0; e_und = 1;
              if (e_su != 65535) e_su++;
            end
          end
        end
        case (m_wmode)
          0: if (de_r) begin
            if (n_pre < NB) begin m_wmode = 1; e_wr_active = 1; e_wr_bank = m_wp; end
            else begin m_wmode = 2; e_ovr = 1; if (e_so != 65535) e_so++; end
          end
          1: if (de_f) begin
            mq_bank.push_back(m_wp); mq_src.push_back(m_src);
            m_wp = (m_wp + 1) % NB; m_src = (m_src + 1) % (1 << LW);
            e_wr_active = 0; m_wmode = 0;
          end
          default: if (de_f) begin m_src = (m_src + 1) % (1 << LW); m_wmode = 0; end
        endcase
      end
      e_fill = mq_bank.size();
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("wr_active", int'(bus.wr_active), e_wr_active);
    chk("rd_valid", int'(bus.rd_valid), e_rd_valid);
    chk("fill_level", int'(bus.fill_level), e_fill);
    chk("overrun", int'(bus.overrun), e_ovr);
    chk("underrun", int'(bus.underrun), e_und);
    if (e_wr_active != 0) chk("wr_bank", int'(bus.wr_bank), e_wr_bank);
    if (e_rd_valid != 0) begin
      chk("rd_bank", int'(bus.rd_bank), e_rd_bank);
      chk("rd_rep", int'(bus.rd_rep), e_rd_rep);
      chk("rd_src_line", int'(bus.rd_src_line), e_rd_src);
    end
`ifdef SCALER_SCHED_STATS_EN
    chk("stat_overruns", int'(bus.stat_overruns), e_so);
    chk("stat_underruns", int'(bus.stat_underruns), e_su);
`endif
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic nline(input int len);
    bus.in_de = 1'b1;
    repeat (len) tick();
    bus.in_de = 1'b0;
    repeat (2) tick();
  endtask

  task automatic vsync();
    bus.in_vs = 1'b1; tick();
    bus.in_vs = 1'b0; tick();
  endtask

  task automatic out_line(output int v, output int b, output int r, output int s);
    bus.out_line_req = 1'b1; tick();
    bus.out_line_req = 1'b0;
    v = int'(bus.rd_valid); b = int'(bus.rd_bank); r = int'(bus.rd_rep); s = int'(bus.rd_src_line);
    repeat (2) tick();
    bus.out_line_done = 1'b1; tick();
    bus.out_line_done = 1'b0; tick();
  endtask

  task automatic all_zero(input string tag);
    chk({tag, "_wr_active"}, int'(bus.wr_active), 0);
    chk({tag, "_rd_valid"}, int'(bus.rd_valid), 0);
    chk({tag, "_fill"}, int'(bus.fill_level), 0);
    chk({tag, "_wr_bank"}, int'(bus.wr_bank), 0);
    chk({tag, "_rd_src"}, int'(bus.rd_src_line), 0);
  endtask

  int v, b, r, s, run;

  initial begin
    rst_n = 1'b0;
    bus.in_de = 1'b0; bus.in_vs = 1'b0; bus.out_line_req = 1'b0; bus.out_line_done = 1'b0;
    repeat (3) tick();
    all_zero("reset");
    rst_n = 1'b1;
    tick();

    // Steady state: one native line then three replicas, six times.
    vsync();
    for (int k = 0; k < 18; k++) begin
      if (k % 3 == 0) nline($urandom_range(3, 8));
      out_line(v, b, r, s);
      chk("steady_valid", v, 1);
      chk("steady_bank", b, (k / 3) % 3);
      chk("steady_rep", r, k % 3);
      chk("steady_src", s, k / 3);
    end
    chk("model_fill_steady", e_fill, 0);

    // Prime: a request before the first line completes is served black without underrun.
    vsync();
    bus.in_de = 1'b1; tick();
    bus.out_line_req = 1'b1; tick();
    bus.out_line_req = 1'b0;
    chk("prime_valid", int'(bus.rd_valid), 0);
    chk("prime_underrun", int'(bus.underrun), 0);
    tick();
    bus.in_de = 1'b0; repeat (2) tick();
    out_line(v, b, r, s);
    chk("prime_served", v, 1);
    chk("prime_bank", b, 0);
    chk("prime_src", s, 0);
    out_line(v, b, r, s);
    out_line(v, b, r, s);

    // Overrun: four lines with no readout; the fourth is dropped.
    vsync();
    repeat (3) nline(4);
    chk("ovr_fill", int'(bus.fill_level), 3);
    bus.in_de = 1'b1; tick();
    chk("ovr_pulse", int'(bus.overrun), 1);
    chk("ovr_wr_active", int'(bus.wr_active), 0);
    repeat (4) tick();
    bus.in_de = 1'b0; repeat (2) tick();
    for (int k = 0; k < 9; k++) begin
      out_line(v, b, r, s);
      chk("ovr_read_src", s, k / 3);
    end

    // Underrun: ring drained while running.
    chk("udr_fill", int'(bus.fill_level), 0);
    bus.out_line_req = 1'b1; tick();
    bus.out_line_req = 1'b0;
    chk("udr_valid", int'(bus.rd_valid), 0);
    chk("udr_pulse", int'(bus.underrun), 1);
    tick();
    chk("udr_pulse_width", int'(bus.underrun), 0);
    nline(5);
    out_line(v, b, r, s);
    chk("udr_recover_valid", v, 1);
    chk("udr_recover_rep", r, 0);
    chk("udr_recover_src", s, 4);
    chk("udr_recover_bank", b, 0);

    // Vsync during an active line aborts it and restarts the ring.
    bus.in_de = 1'b1; repeat (2) tick();
    bus.in_vs = 1'b1; tick();
    chk("vsmid_wr_active", int'(bus.wr_active), 0);
    chk("vsmid_fill", int'(bus.fill_level), 0);
    bus.in_vs = 1'b0; tick();
    bus.in_de = 1'b0; repeat (2) tick();
    bus.in_de = 1'b1; tick();
    chk("vsmid_next_active", int'(bus.wr_active), 1);
    chk("vsmid_next_bank", int'(bus.wr_bank), 0);
    repeat (3) tick();
    bus.in_de = 1'b0; repeat (2) tick();
    out_line(v, b, r, s);
    chk("vsmid_read_src", s, 0);

    // Randomised traffic with occasional vsync.
    run = 0;
    for (int c = 0; c < 4000; c++) begin
      bus.in_vs = ($urandom_range(0, 499) == 0);
      bus.out_line_req = ($urandom_range(0, 5) == 0);
      bus.out_line_done = ($urandom_range(0, 4) == 0);
      if (run == 0) begin
        bus.in_de = ~bus.in_de;
        run = bus.in_de ? $urandom_range(2, 10) : $urandom_range(1, 6);
      end
      run--;
      tick();
    end
    bus.in_vs = 1'b0; bus.out_line_req = 1'b0; bus.out_line_done = 1'b0; bus.in_de = 1'b0;
    repeat (3) tick();

    // Asynchronous reset mid-line clears outputs without a clock edge.
    vsync();
    bus.in_de = 1'b1; repeat (2) tick();
    chk("arst_pre_active", int'(bus.wr_active), 1);
    #2 rst_n = 1'b0;
    #1 all_zero("arst");
    bus.in_de = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    bus.in_de = 1'b1; tick();
    chk("arst_next_bank", int'(bus.wr_bank), 0);
    chk("arst_next_active", int'(bus.wr_active), 1);
    repeat (3) tick();
    bus.in_de = 1'b0; repeat (3) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
